// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode constants and immediate-format codes for the immediate-decode stage.
package imm_gen_stage_pkg;

  // Base RV32/RV64 major opcodes (inst[6:0])
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  typedef logic [2:0] imm_type_t;

  // Immediate format codes carried alongside the instruction
  localparam imm_type_t IMM_I    = 3'b000;
  localparam imm_type_t IMM_S    = 3'b001;
  localparam imm_type_t IMM_B    = 3'b010;
  localparam imm_type_t IMM_U    = 3'b011;
  localparam imm_type_t IMM_J    = 3'b100;
  localparam imm_type_t IMM_Z    = 3'b101;
  localparam imm_type_t IMM_NONE = 3'b111;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate classifier/generator: inst -> {format, XLEN immediate, illegal}.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CSR_IMM = 1
) (
  input  logic [31:0]     inst,
  output imm_type_t       imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0] opcode;

  assign opcode  = inst[6:0];
  // Anything not ending in 2'b11 is a compressed/other-length encoding
  assign illegal = (inst[1:0] != 2'b11);

  // Classify the opcode and assemble the matching sign/zero-extended immediate
  always_comb begin
    imm_type = IMM_NONE;
    imm      = '0;
    if (!illegal) begin
      case (opcode)
        OP_ARI_ITYPE, OP_JALR, OP_LOAD: begin
          imm_type = IMM_I;
          imm      = XLEN'($signed(inst[31:20]));
        end
        OP_STORE: begin
          imm_type = IMM_S;
          imm      = XLEN'($signed({inst[31:25], inst[11:7]}));
        end
        OP_BRANCH: begin
          imm_type = IMM_B;
          imm      = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        end
        OP_LUI, OP_AUIPC: begin
          imm_type = IMM_U;
          imm      = XLEN'($signed({inst[31:12], 12'b0}));
        end
        OP_JAL: begin
          imm_type = IMM_J;
          imm      = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        end
        OP_SYSTEM: begin
          // funct3[2] selects the CSR*I forms whose rs1 field is a 5-bit zimm
          if ((CSR_IMM != 0) && inst[14]) begin
            imm_type = IMM_Z;
            imm      = XLEN'(inst[19:15]);
          end
        end
        default: begin
          imm_type = IMM_NONE;
          imm      = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-decode stage with valid/ready handshake, flush and optional skid entry.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SKID    = 0,
  parameter int CSR_IMM = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_imm_type,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  imm_type_t       dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN), .CSR_IMM(CSR_IMM)) u_imm_decode (
    .inst     (in_inst),
    .imm_type (dec_type),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  logic            out_valid_reg;
  logic [31:0]     out_inst_reg;
  logic [XLEN-1:0] out_pc_reg;
  imm_type_t       out_type_reg;
  logic [XLEN-1:0] out_imm_reg;
  logic            out_illegal_reg;

  // Skid entry view; tied off when the skid buffer is not built
  logic            skid_valid;
  logic [31:0]     skid_inst;
  logic [XLEN-1:0] skid_pc;
  imm_type_t       skid_type;
  logic [XLEN-1:0] skid_imm;
  logic            skid_illegal;

  logic accept;
  logic out_free;

  assign accept   = in_valid & in_ready;
  assign out_free = !out_valid_reg | out_ready;

  // Output register: refill from the skid entry first so order is preserved
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_inst_reg    <= '0;
      out_pc_reg      <= '0;
      out_type_reg    <= IMM_NONE;
      out_imm_reg     <= '0;
      out_illegal_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid_reg   <= 1'b1;
        out_inst_reg    <= skid_inst;
        out_pc_reg      <= skid_pc;
        out_type_reg    <= skid_type;
        out_imm_reg     <= skid_imm;
        out_illegal_reg <= skid_illegal;
      end else if (accept) begin
        out_valid_reg   <= 1'b1;
        out_inst_reg    <= in_inst;
        out_pc_reg      <= in_pc;
        out_type_reg    <= dec_type;
        out_imm_reg     <= dec_imm;
        out_illegal_reg <= dec_illegal;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  generate
    if (SKID != 0) begin : gen_skid
      logic            skid_valid_reg;
      logic            in_ready_reg;
      logic [31:0]     skid_inst_reg;
      logic [XLEN-1:0] skid_pc_reg;
      imm_type_t       skid_type_reg;
      logic [XLEN-1:0] skid_imm_reg;
      logic            skid_illegal_reg;

      // Park an accepted input while the output is stalled; in_ready mirrors "skid empty"
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_valid_reg   <= 1'b0;
          in_ready_reg     <= 1'b1;
          skid_inst_reg    <= '0;
          skid_pc_reg      <= '0;
          skid_type_reg    <= IMM_NONE;
          skid_imm_reg     <= '0;
          skid_illegal_reg <= 1'b0;
        end else if (flush || out_free) begin
          // Flush drops the entry; a free output drains it
          skid_valid_reg <= 1'b0;
          in_ready_reg   <= 1'b1;
        end else if (accept) begin
          skid_valid_reg   <= 1'b1;
          in_ready_reg     <= 1'b0;
          skid_inst_reg    <= in_inst;
          skid_pc_reg      <= in_pc;
          skid_type_reg    <= dec_type;
          skid_imm_reg     <= dec_imm;
          skid_illegal_reg <= dec_illegal;
        end
      end

      assign in_ready     = in_ready_reg;
      assign skid_valid   = skid_valid_reg;
      assign skid_inst    = skid_inst_reg;
      assign skid_pc      = skid_pc_reg;
      assign skid_type    = skid_type_reg;
      assign skid_imm     = skid_imm_reg;
      assign skid_illegal = skid_illegal_reg;
    end else begin : gen_pass
      assign in_ready     = out_free;
      assign skid_valid   = 1'b0;
      assign skid_inst    = '0;
      assign skid_pc      = '0;
      assign skid_type    = IMM_NONE;
      assign skid_imm     = '0;
      assign skid_illegal = 1'b0;
    end
  endgenerate

  assign out_valid    = out_valid_reg;
  assign out_inst     = out_inst_reg;
  assign out_pc       = out_pc_reg;
  assign out_imm_type = out_type_reg;
  assign out_imm      = out_imm_reg;
  assign out_illegal  = out_illegal_reg;

endmodule
